// File: rtl/io_output_if.sv
// io_output_if
//   Groups the CPU store/readback bus and the four peripheral output
//   channels of the io_output block.
//   master : the CPU/peripheral side; drives address, data, strobe and acks.
//   slave  : the io_output block; drives port data, valid flags and readback.
//   Signals:
//     addr, datain, write_io_enable : CPU store bus
//     io_read_data                  : combinational CPU readback
//     out_port0..3, out_valid       : per-port data and "new data pending"
//     out_ack                       : per-port peripheral acknowledge
interface io_output_if;
  logic [31:0] addr;
  logic [31:0] datain;
  logic        write_io_enable;
  logic [3:0]  out_ack;
  logic [31:0] out_port0;
  logic [31:0] out_port1;
  logic [31:0] out_port2;
  logic [31:0] out_port3;
  logic [3:0]  out_valid;
  logic [31:0] io_read_data;

  modport master (
    output addr, datain, write_io_enable, out_ack,
    input  out_port0, out_port1, out_port2, out_port3, out_valid, io_read_data
  );

  modport slave (
    input  addr, datain, write_io_enable, out_ack,
    output out_port0, out_port1, out_port2, out_port3, out_valid, io_read_data
  );
endinterface

// File: rtl/io_output.sv
// io_output
//   Memory-mapped output-port block. CPU stores to 0x80/0x84/0x88/0x8C load
//   four 32-bit output registers, each with a valid/ack handshake toward its
//   peripheral and a sticky overrun flag. 0x90 is a read-only status word,
//   0x94 is a write-1-to-clear overrun register (reads as zero).
//   Ports:
//     io_clk : I/O clock, all state changes on its rising edge
//     resetn : synchronous active-low reset
//     bus    : io_output_if.slave (store bus, readback, port channels)
//   Parameter:
//     RST_VAL : value loaded into every output port register on reset
module io_output #(
  parameter logic [31:0] RST_VAL = 32'h0000_0000
) (
  input  logic        io_clk,
  input  logic        resetn,
  io_output_if.slave  bus
);

  localparam logic [5:0] SEL_STATUS  = 6'b100100;
  localparam logic [5:0] SEL_OVR_CLR = 6'b100101;

  logic [31:0] port_q [4];
  logic [31:0] port_d [4];
  logic [3:0]  valid_q, valid_d;
  logic [3:0]  overrun_q, overrun_d;
  logic [5:0]  sel;

  assign sel = bus.addr[7:2];

  // Next-state logic. Acks clear pending flags first; a port write applied
  // afterwards re-sets the flag, which is how "write wins over ack" falls
  // out. Overrun only counts when the old data was neither consumed by an
  // ack this cycle nor already acknowledged.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      port_d[i] = port_q[i];
    end
    overrun_d = overrun_q;
    valid_d   = valid_q & ~bus.out_ack;

    if (bus.write_io_enable) begin
      // sel[5:2] == 4'b1000 covers exactly the four port addresses
      if (sel[5:2] == 4'b1000) begin
        port_d[sel[1:0]]  = bus.datain;
        valid_d[sel[1:0]] = 1'b1;
        if (valid_q[sel[1:0]] && !bus.out_ack[sel[1:0]]) begin
          overrun_d[sel[1:0]] = 1'b1;
        end
      end else if (sel == SEL_OVR_CLR) begin
        overrun_d = overrun_q & ~bus.datain[3:0];
      end
    end
  end

  // State registers; reset overrides any same-cycle write or ack.
  always_ff @(posedge io_clk) begin
    if (!resetn) begin
      for (int i = 0; i < 4; i++) begin
        port_q[i] <= RST_VAL;
      end
      valid_q   <= 4'b0000;
      overrun_q <= 4'b0000;
    end else begin
      for (int i = 0; i < 4; i++) begin
        port_q[i] <= port_d[i];
      end
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  // Combinational readback with no side effects; unmapped addresses and the
  // clear register read as zero.
  always_comb begin
    bus.io_read_data = 32'h0;
    if (sel[5:2] == 4'b1000) begin
      bus.io_read_data = port_q[sel[1:0]];
    end else if (sel == SEL_STATUS) begin
      bus.io_read_data = {24'h0, overrun_q, valid_q};
    end
  end

  assign bus.out_port0 = port_q[0];
  assign bus.out_port1 = port_q[1];
  assign bus.out_port2 = port_q[2];
  assign bus.out_port3 = port_q[3];
  assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_io_output.sv
// tb_io_output
//   Self-checking bench for io_output: directed scenarios followed by
//   randomized store/ack/reset traffic, compared against a behavioural
//   model of the register map kept in the bench.
module tb_io_output;

  localparam logic [31:0] RST_VAL = 32'hC0FF_EE01;

  logic io_clk;
  logic resetn;
  int   checks;
  int   errors;

  io_output_if bus ();

  io_output #(.RST_VAL(RST_VAL)) dut (
    .io_clk (io_clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial io_clk = 1'b0;
  always #5 io_clk = ~io_clk;

  // Reference model: the architectural register file as software sees it.
  logic [31:0] m_port [4];
  logic [3:0]  m_valid;
  logic [3:0]  m_ovr;

  // What a CPU load from address a should return right now.
  function automatic logic [31:0] model_read(input logic [31:0] a);
    int word;
    word = int'(a[7:0]) / 4;
    if (word >= 32 && word <= 35) return m_port[word - 32];
    if (word == 36) return {24'h0, m_ovr, m_valid};
    return 32'h0;
  endfunction

  // One clock edge of the register map's behaviour.
  task automatic model_step(input logic rstn, input logic we,
                            input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] ack);
    int word;
    int n;
    logic [3:0] nv;
    if (!rstn) begin
      for (int i = 0; i < 4; i++) m_port[i] = RST_VAL;
      m_valid = 4'h0;
      m_ovr   = 4'h0;
      return;
    end
    nv = m_valid;
    for (int i = 0; i < 4; i++) if (ack[i]) nv[i] = 1'b0;
    word = int'(a[7:0]) / 4;
    if (we) begin
      if (word >= 32 && word <= 35) begin
        n = word - 32;
        // old data still pending and not consumed this cycle -> lost
        if (m_valid[n] == 1'b1 && ack[n] == 1'b0) m_ovr[n] = 1'b1;
        m_port[n] = d;
        nv[n] = 1'b1;
      end else if (word == 37) begin
        for (int i = 0; i < 4; i++) if (d[i]) m_ovr[i] = 1'b0;
      end
    end
    m_valid = nv;
  endtask

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Compare all visible registers against the model after an edge.
  task automatic checkState();
    checkOutput("port0", bus.out_port0, m_port[0]);
    checkOutput("port1", bus.out_port1, m_port[1]);
    checkOutput("port2", bus.out_port2, m_port[2]);
    checkOutput("port3", bus.out_port3, m_port[3]);
    checkOutput("valid", {28'h0, bus.out_valid}, {28'h0, m_valid});
    checkOutput("rdata_post", bus.io_read_data, model_read(bus.addr));
  endtask

  // Drive one cycle of inputs away from the edge, check the readback before
  // the edge, advance the model at the edge and check state just after it.
  task automatic applyStimulus(input logic rstn, input logic we,
                               input logic [31:0] a, input logic [31:0] d,
                               input logic [3:0] ack);
    @(negedge io_clk);
    resetn              = rstn;
    bus.write_io_enable = we;
    bus.addr            = a;
    bus.datain          = d;
    bus.out_ack         = ack;
    #1;
    checkOutput("rdata_pre", bus.io_read_data, model_read(a));
    @(posedge io_clk);
    model_step(rstn, we, a, d, ack);
    #1;
    checkState();
  endtask

  logic [31:0] status;
  logic [31:0] addr_pool [10];

  initial begin
    checks = 0;
    errors = 0;
    resetn = 1'b0;
    bus.write_io_enable = 1'b0;
    bus.addr    = 32'h0;
    bus.datain  = 32'h0;
    bus.out_ack = 4'h0;
    for (int i = 0; i < 4; i++) m_port[i] = RST_VAL;
    m_valid = 4'h0;
    m_ovr   = 4'h0;

    // Reset with a competing store
    applyStimulus(1'b0, 1'b1, 32'h80, 32'hDEAD_BEEF, 4'h0);
    applyStimulus(1'b0, 1'b1, 32'h80, 32'hDEAD_BEEF, 4'h0);
    checkOutput("rst_port0", bus.out_port0, RST_VAL);
    checkOutput("rst_valid", {28'h0, bus.out_valid}, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h90, 32'h0, 4'h0);
    checkOutput("rst_status", bus.io_read_data, 32'h0);

    // Basic write then ack
    applyStimulus(1'b1, 1'b1, 32'h84, 32'h1234_5678, 4'h0);
    checkOutput("basic_port1", bus.out_port1, 32'h1234_5678);
    checkOutput("basic_valid", {28'h0, bus.out_valid}, 32'h2);
    applyStimulus(1'b1, 1'b0, 32'h90, 32'h0, 4'h0);
    checkOutput("basic_status", bus.io_read_data, 32'h02);
    applyStimulus(1'b1, 1'b0, 32'h90, 32'h0, 4'b0010);
    checkOutput("ack_valid", {28'h0, bus.out_valid}, 32'h0);
    checkOutput("ack_port1", bus.out_port1, 32'h1234_5678);

    // Overrun and its clear
    applyStimulus(1'b1, 1'b1, 32'h88, 32'hA, 4'h0);
    applyStimulus(1'b1, 1'b1, 32'h88, 32'hB, 4'h0);
    checkOutput("ovr_port2", bus.out_port2, 32'hB);
    applyStimulus(1'b1, 1'b0, 32'h90, 32'h0, 4'h0);
    checkOutput("ovr_status", bus.io_read_data, 32'h44);
    applyStimulus(1'b1, 1'b1, 32'h94, 32'h4, 4'h0);
    applyStimulus(1'b1, 1'b0, 32'h90, 32'h0, 4'h0);
    checkOutput("ovr_clr_status", bus.io_read_data, 32'h04);

    // Same-cycle write and ack on port 3
    applyStimulus(1'b1, 1'b1, 32'h8C, 32'h33, 4'h0);
    applyStimulus(1'b1, 1'b1, 32'h8C, 32'h55, 4'b1000);
    checkOutput("wa_port3", bus.out_port3, 32'h55);
    checkOutput("wa_valid3", {31'h0, bus.out_valid[3]}, 32'h1);
    applyStimulus(1'b1, 1'b0, 32'h90, 32'h0, 4'h0);
    status = bus.io_read_data;
    checkOutput("wa_ovr3", {31'h0, status[7]}, 32'h0);

    // Decode: status is read-only, unmapped ignored, upper bits alias
    applyStimulus(1'b1, 1'b1, 32'h90, 32'hFFFF_FFFF, 4'h0);
    applyStimulus(1'b1, 1'b1, 32'hC0, 32'hFFFF_FFFF, 4'h0);
    checkOutput("unmapped_read", bus.io_read_data, 32'h0);
    applyStimulus(1'b1, 1'b1, 32'h1080, 32'h0000_CAFE, 4'h0);
    checkOutput("alias_port0", bus.out_port0, 32'h0000_CAFE);

    // Spurious acks, then reset in the middle of pending traffic
    applyStimulus(1'b1, 1'b0, 32'h90, 32'h0, 4'hF);
    applyStimulus(1'b1, 1'b0, 32'h90, 32'h0, 4'hF);
    checkOutput("spur_valid", {28'h0, bus.out_valid}, 32'h0);
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b1, 1'b1, 32'h80 + 32'(i * 4), 32'h100 + 32'(i), 4'h0);
    checkOutput("all_valid", {28'h0, bus.out_valid}, 32'hF);
    applyStimulus(1'b0, 1'b1, 32'h84, 32'h9999_9999, 4'hF);
    checkOutput("midrst_valid", {28'h0, bus.out_valid}, 32'h0);
    checkOutput("midrst_port3", bus.out_port3, RST_VAL);

    // Randomized traffic against the model
    addr_pool = '{32'h80, 32'h84, 32'h88, 32'h8C, 32'h90, 32'h94,
                  32'hC0, 32'h1080, 32'hFFFF_FF8C, 32'h0};
    for (int k = 0; k < 500; k++) begin
      logic [31:0] a;
      a = addr_pool[$urandom_range(0, 9)];
      if ($urandom_range(0, 9) == 0) a = $urandom;
      applyStimulus(($urandom_range(0, 49) != 0), 1'($urandom_range(0, 1)),
                    a, $urandom, 4'($urandom_range(0, 15)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
